// File: rtl/wb_port_scheduler.sv
// Write-back port arbiter: merges ALU results and a small load-return FIFO onto one
// register-file write port, tracks in-flight load destinations and guards loads from starvation.
module wb_port_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int BUF_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wb_en,
  input  logic [3:0]  alu_dest,
  input  logic [31:0] alu_result,
  input  logic        mem_wb_en,
  input  logic [3:0]  mem_dest,
  input  logic [31:0] mem_result,
  output logic        mem_ready,
  input  logic        issue_en,
  input  logic [3:0]  issue_dest,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  output logic        hazard,
  output logic        alu_stall,
  output logic        writeBackEn,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_WB,
  output logic        proto_err
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(BUF_DEPTH);

  logic [3:0]    buf_dest_q [BUF_DEPTH];
  logic [31:0]   buf_data_q [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   pending_q, pending_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          alu_stall_q, alu_stall_d;
  logic          proto_err_q, proto_err_d;

  logic          buf_empty, push, pop, alu_grant, head_blocked;
  logic [3:0]    head_dest;
  logic [31:0]   head_data;

  assign buf_empty = (count_q == '0);
  assign mem_ready = (count_q < DEPTH_C);
  assign alu_grant = alu_wb_en & ~alu_stall_q;
  // A forced stall cycle always hands the port to the buffer, even if the ALU ignores it.
  assign pop       = ~buf_empty & (~alu_wb_en | alu_stall_q);
  assign push      = mem_wb_en & mem_ready;
  assign head_dest = buf_dest_q[rd_ptr_q];
  assign head_data = buf_data_q[rd_ptr_q];

  assign hazard    = pending_q[src1] | (two_src & pending_q[src2]);
  assign alu_stall = alu_stall_q;
  assign proto_err = proto_err_q;

  always_comb begin
    writeBackEn = 1'b0;
    Dest_wb     = '0;
    Result_WB   = '0;
    if (alu_grant) begin
      writeBackEn = 1'b1;
      Dest_wb     = alu_dest;
      Result_WB   = alu_result;
    end else if (pop) begin
      writeBackEn = 1'b1;
      Dest_wb     = head_dest;
      Result_WB   = head_data;
    end
  end

  always_comb begin
    count_d   = count_q + CW'(push) - CW'(pop);
    pending_d = pending_q;
    if (pop)
      pending_d[head_dest] = 1'b0;
    if (issue_en)
      pending_d[issue_dest] = 1'b1;

    head_blocked = ~buf_empty & ~pop;
    starve_d     = '0;
    alu_stall_d  = 1'b0;
    if (head_blocked) begin
      if (starve_q == STARVE_LAST)
        alu_stall_d = 1'b1;
      else
        starve_d = starve_q + 1'b1;
    end

    proto_err_d = proto_err_q
                | (alu_wb_en & alu_stall_q)
                | (alu_grant & pending_q[alu_dest])
                | (mem_wb_en & ~mem_ready);
  end

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        buf_dest_q[gi] <= '0;
        buf_data_q[gi] <= '0;
      end else if (push && (wr_ptr_q == PW'(gi))) begin
        buf_dest_q[gi] <= mem_dest;
        buf_data_q[gi] <= mem_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      pending_q   <= pending_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Bench for wb_port_scheduler: directed scenarios plus random traffic, all checked against
// a queue-based reference of the arbitration, pending and starvation rules.
module tb_wb_port_scheduler;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wb_en = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [31:0] alu_result = '0;
  logic        mem_wb_en = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic [31:0] mem_result = '0;
  logic        mem_ready;
  logic        issue_en = 1'b0;
  logic [3:0]  issue_dest = '0;
  logic [3:0]  src1 = '0;
  logic [3:0]  src2 = '0;
  logic        two_src = 1'b0;
  logic        hazard;
  logic        alu_stall;
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        proto_err;

  wb_port_scheduler #(.STARVE_LIMIT(LIMIT), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_en(alu_wb_en), .alu_dest(alu_dest), .alu_result(alu_result),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
    .mem_ready(mem_ready),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .src1(src1), .src2(src2), .two_src(two_src),
    .hazard(hazard), .alu_stall(alu_stall),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic [3:0] d; logic [31:0] v; } ent_t;
  ent_t     mq[$];
  bit [15:0] m_pend;
  int       m_streak;
  bit       m_stall;
  bit       m_perr;

  logic        o_wb, o_ready, o_hz, o_stall, o_perr;
  logic [3:0]  o_dest;
  logic [31:0] o_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pend   = '0;
    m_streak = 0;
    m_stall  = 1'b0;
    m_perr   = 1'b0;
  endtask

  task automatic idle();
    alu_wb_en = 1'b0; alu_dest = '0; alu_result = '0;
    mem_wb_en = 1'b0; mem_dest = '0; mem_result = '0;
    issue_en = 1'b0; issue_dest = '0;
    src1 = '0; src2 = '0; two_src = 1'b0;
  endtask

  // Inputs are set by the caller just after a posedge; outputs are checked on the negedge.
  task automatic step();
    bit   alu_g, head_g;
    int   sz;
    ent_t e;
    logic [3:0]  x_dest;
    logic [31:0] x_data;
    @(negedge clk);
    sz     = mq.size();
    alu_g  = alu_wb_en && !m_stall;
    head_g = !alu_g && (sz > 0);
    x_dest = alu_g ? alu_dest : (head_g ? mq[0].d : 4'd0);
    x_data = alu_g ? alu_result : (head_g ? mq[0].v : 32'd0);
    o_wb = writeBackEn; o_dest = Dest_wb; o_data = Result_WB; o_ready = mem_ready;
    o_hz = hazard; o_stall = alu_stall; o_perr = proto_err;
    $display("cyc %0d alu=%0d/%0d mem=%0d/%0d iss=%0d/%0d -> wb=%0d d=%0d r=%h rdy=%0d hz=%0d st=%0d pe=%0d",
             cyc, alu_wb_en, alu_dest, mem_wb_en, mem_dest, issue_en, issue_dest,
             o_wb, o_dest, o_data, o_ready, o_hz, o_stall, o_perr);
    check("wb_en",     o_wb,    (alu_g || head_g));
    check("wb_dest",   o_dest,  x_dest);
    check("wb_data",   o_data,  x_data);
    check("mem_ready", o_ready, (sz < DEPTH));
    check("hazard",    o_hz,    (m_pend[src1] || (two_src && m_pend[src2])));
    check("alu_stall", o_stall, m_stall);
    check("proto_err", o_perr,  m_perr);

    if ((alu_wb_en && m_stall) || (alu_g && m_pend[alu_dest]) || (mem_wb_en && sz >= DEPTH))
      m_perr = 1'b1;
    if (head_g) begin
      e = mq.pop_front();
      m_pend[e.d] = 1'b0;
    end
    if (issue_en)
      m_pend[issue_dest] = 1'b1;
    if (mem_wb_en && sz < DEPTH)
      mq.push_back('{d: mem_dest, v: mem_result});
    if (sz > 0 && !head_g) begin
      m_streak++;
      if (m_streak == LIMIT) begin
        m_stall  = 1'b1;
        m_streak = 0;
      end else begin
        m_stall = 1'b0;
      end
    end else begin
      m_streak = 0;
      m_stall  = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Source selects are left alone so the hazard check sees the real pending bits being cleared.
  task automatic do_reset();
    alu_wb_en = 1'b0; mem_wb_en = 1'b0; issue_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_mem_ready", mem_ready,   1);
    check("rst_hazard",    hazard,      0);
    check("rst_wb_en",     writeBackEn, 0);
    check("rst_wb_dest",   Dest_wb,     0);
    check("rst_wb_data",   Result_WB,   0);
    check("rst_proto_err", proto_err,   0);
    check("rst_alu_stall", alu_stall,   0);
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rand_cycle(input bit legal);
    alu_wb_en  = 1'($urandom_range(0, 1));
    alu_dest   = 4'($urandom_range(0, 15));
    alu_result = $urandom;
    mem_wb_en  = 1'($urandom_range(0, 1));
    mem_dest   = 4'($urandom_range(0, 15));
    mem_result = $urandom;
    issue_en   = ($urandom_range(0, 3) == 0);
    issue_dest = 4'($urandom_range(0, 15));
    src1       = 4'($urandom_range(0, 15));
    src2       = 4'($urandom_range(0, 15));
    two_src    = 1'($urandom_range(0, 1));
    if (legal) begin
      if (m_stall || m_pend[alu_dest]) alu_wb_en = 1'b0;
      if (mq.size() >= DEPTH) mem_wb_en = 1'b0;
    end
    step();
  endtask

  initial begin
    model_clear();
    idle();
    @(posedge clk); #1;
    do_reset();

    // ALU write goes straight to the port in the same cycle
    alu_wb_en = 1; alu_dest = 3; alu_result = 32'h55; step();
    check("r035_wb_en", o_wb, 1); check("r035_dest", o_dest, 3); check("r035_data", o_data, 32'h55);

    // Load-use hazard clears after the load writes back
    idle(); issue_en = 1; issue_dest = 5; step();
    idle(); src1 = 5; mem_wb_en = 1; mem_dest = 5; mem_result = 32'hAB; step();
    check("r036_hz_set", o_hz, 1); check("r036_no_bypass", o_wb, 0);
    idle(); src1 = 5; step();
    check("r036_wb_dest", o_dest, 5); check("r036_wb_data", o_data, 32'hAB);
    idle(); src1 = 5; step();
    check("r036_hz_clear", o_hz, 0);

    // Issue and head grant to R7 in the same cycle: set wins
    do_reset();
    issue_en = 1; issue_dest = 7; mem_wb_en = 1; mem_dest = 7; mem_result = 32'h77; step();
    idle(); issue_en = 1; issue_dest = 7; step();
    check("r039_grant_dest", o_dest, 7);
    idle(); src1 = 7; step();
    check("r039_pend_kept", o_hz, 1);

    // Starvation: four blocked cycles, then a forced stall cycle drains the head
    do_reset();
    alu_wb_en = 1; alu_dest = 1; alu_result = 32'h11; mem_wb_en = 1; mem_dest = 9; mem_result = 32'h99; step();
    for (int i = 0; i < LIMIT; i++) begin
      idle(); alu_wb_en = 1; alu_dest = 2; alu_result = 32'h22; step();
      check("r038_no_stall", o_stall, 0);
    end
    idle(); step();
    check("r038_stall", o_stall, 1); check("r038_head_dest", o_dest, 9); check("r038_head_data", o_data, 32'h99);
    idle(); step();
    check("r038_stall_drop", o_stall, 0);

    // Overflow: two loads fill the buffer, the third is a protocol error
    do_reset();
    alu_wb_en = 1; mem_wb_en = 1; mem_dest = 1; mem_result = 32'h1; step();
    alu_wb_en = 1; mem_wb_en = 1; mem_dest = 2; mem_result = 32'h2; step();
    check("r037_ready_before", o_ready, 1);
    alu_wb_en = 1; mem_wb_en = 1; mem_dest = 3; mem_result = 32'h3; step();
    check("r037_ready_full", o_ready, 0);
    idle(); step();
    check("r037_proto_err", o_perr, 1);

    // Reset mid-operation with a full buffer and pending hazard
    idle(); alu_wb_en = 1; mem_wb_en = 1; mem_dest = 4; mem_result = 32'h4; issue_en = 1; issue_dest = 4; step();
    idle(); alu_wb_en = 1; src1 = 4; step();
    check("r040_pre_full", o_ready, 0); check("r040_pre_hz", o_hz, 1);
    do_reset();

    for (int i = 0; i < 400; i++) rand_cycle(1'b1);
    check("legal_no_proto_err", proto_err, 0);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 100; i++) rand_cycle(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
